// File: rtl/reg16_serial_tx.sv
// Parallel-in/serial-out transmitter: frames a WIDTH-bit word as start bit,
// MSB-first data bits and stop bit, each bit held BIT_TICKS clock cycles.
module reg16_serial_tx #(
  parameter int WIDTH     = 16,
  parameter int BIT_TICKS = 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] DATA_IN,
  output logic             READY,
  output logic             BUSY,
  output logic             SOUT,
  output logic             DONE
);

  localparam int TW = $clog2(BIT_TICKS + 1);
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(BIT_TICKS - 1);
  localparam logic [TW-1:0] TICK_PRE  = TW'((BIT_TICKS > 1) ? (BIT_TICKS - 2) : 0);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [TW-1:0]    ticks_q, ticks_d;
  logic [BW-1:0]    bits_q, bits_d;
  logic             sout_q, sout_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             last_tick_s;

  assign last_tick_s = (ticks_q == TICK_LAST);

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    ticks_d = ticks_q;
    bits_d  = bits_q;
    sout_d  = sout_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        sout_d = 1'b1;
        if (LOAD) begin
          shreg_d = DATA_IN;
          ticks_d = '0;
          bits_d  = '0;
          sout_d  = 1'b0;
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (last_tick_s) begin
          ticks_d = '0;
          sout_d  = shreg_q[WIDTH-1];
          state_d = DATA;
        end else begin
          ticks_d = ticks_q + TW'(1);
        end
      end
      DATA: begin
        if (last_tick_s) begin
          ticks_d = '0;
          shreg_d = shreg_q << 1;
          if (bits_q == BIT_LAST) begin
            bits_d  = '0;
            sout_d  = 1'b1;
            state_d = STOP;
            // With one tick per bit the first STOP cycle is also the last one
            done_d  = (BIT_TICKS == 1);
          end else begin
            bits_d = bits_q + BW'(1);
            sout_d = shreg_q[WIDTH-2];
          end
        end else begin
          ticks_d = ticks_q + TW'(1);
        end
      end
      STOP: begin
        sout_d = 1'b1;
        if (last_tick_s) begin
          ticks_d = '0;
          state_d = IDLE;
        end else begin
          ticks_d = ticks_q + TW'(1);
          done_d  = (ticks_q == TICK_PRE);
        end
      end
      default: begin
        ticks_d = '0;
        bits_d  = '0;
        sout_d  = 1'b1;
        state_d = IDLE;
      end
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      shreg_q <= '0;
      ticks_q <= '0;
      bits_q  <= '0;
      sout_q  <= 1'b1;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      ticks_q <= ticks_d;
      bits_q  <= bits_d;
      sout_q  <= sout_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign READY = ready_q;
  assign BUSY  = busy_q;
  assign SOUT  = sout_q;
  assign DONE  = done_q;

endmodule
